reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter IRQ_VECTOR, default 32'h0000_0004, meaning the PC value loaded on interrupt entry.
REQ-003 The block SHALL have parameter STACK_TOP, default 32'h0000_0000, meaning the SP value loaded at reset.
REQ-004 The block SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have ports: rd_sel_a, rd_sel_b  input  reg_pkg::reg_e (4)  read-port register selects.
REQ-007 The block SHALL have ports: rd_data_a, rd_data_b  output  32  read-port data.
REQ-008 The block SHALL have ports: wr_en  input  1; wr_sel  input  reg_e (4); wr_mask  input  reg_pkg::reg_mask_e (2); wr_data  input  32; together these form the write port.
REQ-009 The block SHALL have port: pc_inc  input  1  advance PC by 1.
REQ-010 The block SHALL have ports: alu_status_wr_en  input  1; alu_status_in  input  alu_pkg::alu_status_t  ALU flag update.
REQ-011 The block SHALL have port: irq_req  input  1  interrupt entry request.
REQ-012 The block SHALL have port: irq_taken  output  1  registered one-cycle pulse marking interrupt entry.
REQ-013 The block SHALL have ports: pc_out  output  32; status_out  output  reg_pkg::status_t  current register values.

Function
REQ-014 The block SHALL hold registers R0-R10, SP, LR, PC (32 bits each) and STATUS (status_t); PCLINK SHALL NOT be separate storage.
REQ-015 Reads SHALL be combinational with no write bypass, returning the pre-edge value; PCLINK SHALL read as PC, and STATUS SHALL read as status_t zero-extended to 32 bits.
REQ-016 A write (wr_en=1) SHALL set reg <= (reg & ~m) | (wr_data & m), where m = reg_pkg::mask_32(wr_mask) (LS8=0xFF, LS16=0xFFFF, LS27=0x00FFFFFF, LS32=0xFFFFFFFF).
REQ-017 A write to PCLINK SHALL masked-write PC exactly as a PC write, and in the same edge SHALL set LR <= the pre-edge PC (full 32 bits, unmasked).
REQ-018 A STATUS write SHALL apply the mask to the zero-extended status; when mode==USER, only the alu_status field SHALL change and imask and mode SHALL be preserved.
REQ-019 When alu_status_wr_en=1, the block SHALL set alu_status <= alu_status_in, unless STATUS is written that cycle, in which case the write port wins.
REQ-020 When pc_inc=1, the block SHALL set PC <= PC + 1 (mod 2^32; 0xFFFFFFFF wraps to 0), unless PC or PCLINK is written that cycle, in which case the write wins and pc_inc is ignored.
REQ-021 Interrupt entry SHALL occur when irq_req=1 and imask==0, with the following effects in one edge:
  - LR <= pre-edge PC;
  - PC <= IRQ_VECTOR;
  - mode <= SUPERVISOR;
  - imask <= 1;
  - the alu_status field is preserved;
  - irq_taken = 1 next cycle.
REQ-022 Interrupt entry SHALL take priority over any same-cycle write, pc_inc, or alu_status update to PC, LR, or STATUS; those updates SHALL be dropped, while writes to other registers proceed.
REQ-023 irq_req while imask==1 SHALL have no effect and irq_taken SHALL stay 0; the request is level-sensitive and is not latched.
REQ-024 irq_taken SHALL be high for exactly one cycle per entry; a held irq_req SHALL NOT re-enter, because imask is now 1.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set R0-R10 and LR to 0, PC to RESET_VECTOR, SP to STACK_TOP, alu_status to 0, imask to 1, mode to SUPERVISOR, and irq_taken to 0.
REQ-026 rst SHALL override every other input in the same cycle, including a mid-operation write, PCLINK, or interrupt entry.

Verification
REQ-027 Reset, then R3 LS32 write 0xAABBCCDD, then R3 LS8 write 0x00000011 -> rd R3 = 0xAABBCC11; R3 LS27 write 0xFFFFFFFF -> 0xAAFFFFFF.
REQ-028 PC=0x100, PCLINK LS32 write 0x200 with pc_inc=1 -> PC=0x200, LR=0x100.
REQ-029 In USER mode, STATUS LS32 write of all ones -> alu_status all ones, imask and mode unchanged; in SUPERVISOR mode -> imask=1, mode=USER.
REQ-030 imask=0, PC=0x40, irq_req held 3 cycles with a same-cycle PC write of 0x80 -> PC=0x4, LR=0x40, mode=SUPERVISOR, imask=1, irq_taken high exactly 1 cycle.
REQ-031 PC=0xFFFFFFFF with pc_inc -> PC=0; rst asserted together with wr_en to R1 -> R1=0, PC=RESET_VECTOR, SP=STACK_TOP.

Source files
------------

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- CPU architectural register file.
//
// Holds R0-R10, SP, LR, PC (32 bits each) and STATUS (mode, imask,
// alu_status). PCLINK is not storage: it reads as PC, and writing it updates
// PC and captures the pre-edge PC into LR (call-style link). Interrupt entry
// vectors PC, saves the old PC into LR and switches to supervisor mode with
// interrupts masked.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   rd_sel_a/b             combinational read selects
//   rd_data_a/b            read data (pre-edge values, no write bypass)
//   wr_en/wr_sel/wr_mask/wr_data   masked write port
//   pc_inc                 PC <= PC + 1 when no PC/PCLINK write
//   alu_status_wr_en/alu_status_in ALU flag update
//   irq_req                level-sensitive interrupt request
//   irq_taken              registered one-cycle interrupt entry pulse
//   pc_out, status_out     current PC and STATUS
// ---------------------------------------------------------------------------

package alu_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_status_t;

endpackage

package reg_pkg;

    typedef enum logic [3:0] {
        REG_R0     = 4'd0,
        REG_R1     = 4'd1,
        REG_R2     = 4'd2,
        REG_R3     = 4'd3,
        REG_R4     = 4'd4,
        REG_R5     = 4'd5,
        REG_R6     = 4'd6,
        REG_R7     = 4'd7,
        REG_R8     = 4'd8,
        REG_R9     = 4'd9,
        REG_R10    = 4'd10,
        REG_SP     = 4'd11,
        REG_LR     = 4'd12,
        REG_PC     = 4'd13,
        REG_PCLINK = 4'd14,
        REG_STATUS = 4'd15
    } reg_e;

    typedef enum logic [1:0] {
        LS8  = 2'd0,
        LS16 = 2'd1,
        LS27 = 2'd2,
        LS32 = 2'd3
    } reg_mask_e;

    typedef enum logic {
        MODE_SUPERVISOR = 1'b0,
        MODE_USER       = 1'b1
    } mode_e;

    // Bit layout as read through the register port (zero-extended):
    // [5] mode, [4] imask, [3:0] alu_status.
    typedef struct packed {
        mode_e                 mode;
        logic                  imask;
        alu_pkg::alu_status_t  alu_status;
    } status_t;

    // LS27 deliberately selects the low 24 bits.
    function automatic logic [31:0] mask_32(input reg_mask_e m);
        logic [31:0] r;
        r = '1;
        case (m)
            LS8:     r = 32'h0000_00FF;
            LS16:    r = 32'h0000_FFFF;
            LS27:    r = 32'h00FF_FFFF;
            LS32:    r = 32'hFFFF_FFFF;
            default: r = '1;
        endcase
        return r;
    endfunction

endpackage

module reg_file #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0004,
    parameter logic [31:0] STACK_TOP    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  reg_pkg::reg_e         rd_sel_a,
    input  reg_pkg::reg_e         rd_sel_b,
    output logic [31:0]           rd_data_a,
    output logic [31:0]           rd_data_b,
    input  logic                  wr_en,
    input  reg_pkg::reg_e         wr_sel,
    input  reg_pkg::reg_mask_e    wr_mask,
    input  logic [31:0]           wr_data,
    input  logic                  pc_inc,
    input  logic                  alu_status_wr_en,
    input  alu_pkg::alu_status_t  alu_status_in,
    input  logic                  irq_req,
    output logic                  irq_taken,
    output logic [31:0]           pc_out,
    output reg_pkg::status_t      status_out
);

    import reg_pkg::*;

    localparam int unsigned NUM_GPR  = 11;
    localparam int unsigned STATUS_W = $bits(status_t);

    logic [31:0] gpr_q [NUM_GPR];
    logic [31:0] gpr_d [NUM_GPR];
    logic [31:0] sp_q, sp_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] pc_q, pc_d;
    status_t     status_q, status_d;
    logic        irq_taken_q, irq_taken_d;

    logic [31:0] wmask;
    logic [31:0] pc_merge;
    status_t     status_wr;
    logic [3:0]  wr_idx;
    logic        irq_entry;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wdat,
                                          input logic [31:0] m);
        return (old & ~m) | (wdat & m);
    endfunction

    function automatic logic [31:0] read_port(input reg_e        sel,
                                              input logic [31:0] gpr [NUM_GPR],
                                              input logic [31:0] sp,
                                              input logic [31:0] lr,
                                              input logic [31:0] pc,
                                              input status_t     st);
        logic [31:0] r;
        r = '0;
        case (sel)
            REG_R0:     r = gpr[0];
            REG_R1:     r = gpr[1];
            REG_R2:     r = gpr[2];
            REG_R3:     r = gpr[3];
            REG_R4:     r = gpr[4];
            REG_R5:     r = gpr[5];
            REG_R6:     r = gpr[6];
            REG_R7:     r = gpr[7];
            REG_R8:     r = gpr[8];
            REG_R9:     r = gpr[9];
            REG_R10:    r = gpr[10];
            REG_SP:     r = sp;
            REG_LR:     r = lr;
            REG_PC:     r = pc;
            REG_PCLINK: r = pc;
            REG_STATUS: r = {{(32 - STATUS_W){1'b0}}, st};
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_sel_a, gpr_q, sp_q, lr_q, pc_q, status_q);
        rd_data_b = read_port(rd_sel_b, gpr_q, sp_q, lr_q, pc_q, status_q);
    end

    // Next-state priority, lowest first: pc_inc / ALU flags, then the write
    // port, then interrupt entry (which owns PC, LR and STATUS).
    always_comb begin
        wr_idx      = wr_sel;
        wmask       = mask_32(wr_mask);
        irq_entry   = irq_req & ~status_q.imask;
        pc_merge    = merge(pc_q, wr_data, wmask);
        status_wr   = status_t'((status_q & ~wmask[STATUS_W-1:0]) |
                                (wr_data[STATUS_W-1:0] & wmask[STATUS_W-1:0]));

        gpr_d       = gpr_q;
        sp_d        = sp_q;
        lr_d        = lr_q;
        pc_d        = pc_q;
        status_d    = status_q;
        irq_taken_d = irq_entry;

        if (pc_inc) begin
            pc_d = pc_q + 32'd1;
        end
        if (alu_status_wr_en) begin
            status_d.alu_status = alu_status_in;
        end

        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            if (wr_en && (wr_idx == 4'(i))) begin
                gpr_d[i] = merge(gpr_q[i], wr_data, wmask);
            end
        end

        if (wr_en) begin
            case (wr_sel)
                REG_SP: sp_d = merge(sp_q, wr_data, wmask);
                REG_LR: lr_d = merge(lr_q, wr_data, wmask);
                REG_PC: pc_d = pc_merge;
                REG_PCLINK: begin
                    pc_d = pc_merge;
                    lr_d = pc_q;
                end
                REG_STATUS: begin
                    // User mode may only touch the flags.
                    if (status_q.mode == MODE_USER) begin
                        status_d.alu_status = status_wr.alu_status;
                    end else begin
                        status_d = status_wr;
                    end
                end
                default: ;
            endcase
        end

        if (irq_entry) begin
            lr_d                = pc_q;
            pc_d                = IRQ_VECTOR;
            status_d.mode       = MODE_SUPERVISOR;
            status_d.imask      = 1'b1;
            status_d.alu_status = status_q.alu_status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            sp_q                <= STACK_TOP;
            lr_q                <= '0;
            pc_q                <= RESET_VECTOR;
            status_q.mode       <= MODE_SUPERVISOR;
            status_q.imask      <= 1'b1;
            status_q.alu_status <= '0;
            irq_taken_q         <= 1'b0;
        end else begin
            gpr_q       <= gpr_d;
            sp_q        <= sp_d;
            lr_q        <= lr_d;
            pc_q        <= pc_d;
            status_q    <= status_d;
            irq_taken_q <= irq_taken_d;
        end
    end

    assign irq_taken  = irq_taken_q;
    assign pc_out     = pc_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- scoreboard bench for reg_file.
// The driver applies one stimulus per cycle at the falling edge, pushes the
// outputs the reference model predicts for that cycle, then advances the
// model. The monitor samples shortly after each falling edge and compares.
// ---------------------------------------------------------------------------
module tb_reg_file;

    import reg_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [31:0] IV = 32'h0000_0004;
    localparam logic [31:0] ST = 32'h8000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    reg_e                 rd_sel_a, rd_sel_b, wr_sel;
    logic [31:0]          rd_data_a, rd_data_b;
    logic                 wr_en;
    reg_mask_e            wr_mask;
    logic [31:0]          wr_data;
    logic                 pc_inc;
    logic                 alu_status_wr_en;
    alu_pkg::alu_status_t alu_status_in;
    logic                 irq_req;
    logic                 irq_taken;
    logic [31:0]          pc_out;
    status_t              status_out;

    always #5 clk = ~clk;

    reg_file #(
        .RESET_VECTOR(RV),
        .IRQ_VECTOR  (IV),
        .STACK_TOP   (ST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_sel_a        (rd_sel_a),
        .rd_sel_b        (rd_sel_b),
        .rd_data_a       (rd_data_a),
        .rd_data_b       (rd_data_b),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_mask         (wr_mask),
        .wr_data         (wr_data),
        .pc_inc          (pc_inc),
        .alu_status_wr_en(alu_status_wr_en),
        .alu_status_in   (alu_status_in),
        .irq_req         (irq_req),
        .irq_taken       (irq_taken),
        .pc_out          (pc_out),
        .status_out      (status_out)
    );

    typedef struct {
        bit        rst;
        bit        wr_en;
        bit [3:0]  sel;
        bit [1:0]  mask;
        bit [31:0] data;
        bit        pc_inc;
        bit        alu_en;
        bit [3:0]  alu_in;
        bit        irq;
        bit [3:0]  ra;
        bit [3:0]  rb;
    } stim_t;

    typedef struct {
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] pc;
        bit [31:0] st;
        bit        taken;
        bit        gold_en;
        bit [31:0] gold;
        int        tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tag_n = 0;

    // Reference model: index 0-10 = R0-R10, 11 = SP, 12 = LR, 13 = PC.
    bit [31:0] m_r [14];
    bit [3:0]  m_alu;
    bit        m_imask, m_user, m_taken, m_valid;

    function automatic bit [31:0] m_status32();
        return {26'd0, m_user, m_imask, m_alu};
    endfunction

    function automatic bit [31:0] m_read(input bit [3:0] sel);
        if (sel <= 4'd13) return m_r[sel];
        if (sel == 4'd14) return m_r[13];
        return m_status32();
    endfunction

    function automatic bit [31:0] mask_of(input bit [1:0] m);
        case (m)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_step(input stim_t s);
        bit [31:0] nr [14];
        bit [31:0] mk, oldpc, st;
        bit [3:0]  nalu;
        bit        nimask, nuser, entry;
        if (s.rst) begin
            foreach (m_r[i]) m_r[i] = 32'd0;
            m_r[11] = ST;
            m_r[13] = RV;
            m_alu   = 4'd0;
            m_imask = 1'b1;
            m_user  = 1'b0;
            m_taken = 1'b0;
            m_valid = 1'b1;
            return;
        end
        nr     = m_r;
        nalu   = m_alu;
        nimask = m_imask;
        nuser  = m_user;
        oldpc  = m_r[13];
        mk     = mask_of(s.mask);
        entry  = s.irq && !m_imask;
        if (s.pc_inc) nr[13] = oldpc + 32'd1;
        if (s.alu_en) nalu = s.alu_in;
        if (s.wr_en) begin
            if (s.sel <= 4'd13) begin
                nr[s.sel] = (m_r[s.sel] & ~mk) | (s.data & mk);
            end else if (s.sel == 4'd14) begin
                nr[13] = (oldpc & ~mk) | (s.data & mk);
                nr[12] = oldpc;
            end else begin
                st   = (m_status32() & ~mk) | (s.data & mk);
                nalu = st[3:0];
                if (!m_user) begin
                    nimask = st[4];
                    nuser  = st[5];
                end
            end
        end
        if (entry) begin
            nr[12] = oldpc;
            nr[13] = IV;
            nuser  = 1'b0;
            nimask = 1'b1;
            nalu   = m_alu;
        end
        m_r     = nr;
        m_alu   = nalu;
        m_imask = nimask;
        m_user  = nuser;
        m_taken = entry;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic apply(input stim_t s, input bit gold_en = 1'b0, input bit [31:0] gold = 32'd0);
        exp_t e;
        @(negedge clk);
        rst              = s.rst;
        wr_en            = s.wr_en;
        wr_sel           = reg_e'(s.sel);
        wr_mask          = reg_mask_e'(s.mask);
        wr_data          = s.data;
        pc_inc           = s.pc_inc;
        alu_status_wr_en = s.alu_en;
        alu_status_in    = alu_pkg::alu_status_t'(s.alu_in);
        irq_req          = s.irq;
        rd_sel_a         = reg_e'(s.ra);
        rd_sel_b         = reg_e'(s.rb);
        if (m_valid) begin
            e.a       = m_read(s.ra);
            e.b       = m_read(s.rb);
            e.pc      = m_r[13];
            e.st      = m_status32();
            e.taken   = m_taken;
            e.gold_en = gold_en;
            e.gold    = gold;
            e.tag     = tag_n;
            if (gold_en) tag_n++;
            q.push_back(e);
        end
        model_step(s);
    endtask

    task automatic do_rst();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        apply(s);
    endtask

    task automatic wr(input bit [3:0] sel, input bit [1:0] mk, input bit [31:0] d);
        stim_t s;
        s = idle();
        s.wr_en = 1'b1;
        s.sel   = sel;
        s.mask  = mk;
        s.data  = d;
        apply(s);
    endtask

    task automatic rd(input bit [3:0] sel, input bit [31:0] gold);
        stim_t s;
        s = idle();
        s.ra = sel;
        s.rb = 4'd15;
        apply(s, 1'b1, gold);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [31:0] st_v;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e    = q.pop_front();
                st_v = {26'd0, status_out};
                check("rd_data_a", rd_data_a, e.a);
                check("rd_data_b", rd_data_b, e.b);
                check("pc_out", pc_out, e.pc);
                check("status_out", st_v, e.st);
                check("irq_taken", {31'd0, irq_taken}, {31'd0, e.taken});
                if (e.gold_en) begin
                    check($sformatf("directed#%0d", e.tag), rd_data_a, e.gold);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; wr_en = 1'b0; wr_sel = REG_R0; wr_mask = LS8; wr_data = '0;
        pc_inc = 1'b0; alu_status_wr_en = 1'b0; alu_status_in = '0; irq_req = 1'b0;
        rd_sel_a = REG_R0; rd_sel_b = REG_R0;
        m_valid = 1'b0;

        // Reset state
        do_rst();
        rd(4'd13, RV);           // #0
        rd(4'd11, ST);           // #1
        rd(4'd15, 32'h10);       // #2 supervisor, imask=1

        // Masked writes to R3
        wr(4'd3, 2'd3, 32'hAABB_CCDD);
        wr(4'd3, 2'd0, 32'h0000_0011);
        rd(4'd3, 32'hAABB_CC11);
        wr(4'd3, 2'd2, 32'hFFFF_FFFF);
        rd(4'd3, 32'hAAFF_FFFF);

        // PCLINK write beats pc_inc and links LR
        wr(4'd13, 2'd3, 32'h100);
        s = idle(); s.wr_en = 1; s.sel = 4'd14; s.mask = 2'd3; s.data = 32'h200; s.pc_inc = 1;
        apply(s);
        rd(4'd13, 32'h200);
        rd(4'd12, 32'h100);

        // STATUS writes: supervisor then user
        do_rst();
        wr(4'd15, 2'd3, 32'h20);
        rd(4'd15, 32'h20);
        wr(4'd15, 2'd3, 32'hFFFF_FFFF);
        rd(4'd15, 32'h2F);
        do_rst();
        wr(4'd15, 2'd3, 32'hFFFF_FFFF);
        rd(4'd15, 32'h3F);

        // Interrupt entry with held request and colliding PC write
        do_rst();
        wr(4'd15, 2'd3, 32'h0);
        wr(4'd13, 2'd3, 32'h40);
        s = idle(); s.irq = 1; s.wr_en = 1; s.sel = 4'd13; s.mask = 2'd3; s.data = 32'h80;
        s.ra = 4'd13; s.rb = 4'd12;
        apply(s, 1'b1, 32'h40);
        s = idle(); s.irq = 1; s.ra = 4'd13;
        apply(s, 1'b1, 32'h4);
        s = idle(); s.irq = 1; s.ra = 4'd12;
        apply(s, 1'b1, 32'h40);
        rd(4'd15, 32'h10);

        // PC wrap, then reset beating a write
        wr(4'd13, 2'd3, 32'hFFFF_FFFF);
        s = idle(); s.pc_inc = 1;
        apply(s);
        rd(4'd13, 32'h0);
        wr(4'd1, 2'd3, 32'h5555_5555);
        s = idle(); s.rst = 1; s.wr_en = 1; s.sel = 4'd1; s.mask = 2'd3; s.data = 32'h1234;
        apply(s);
        rd(4'd1, 32'h0);
        rd(4'd13, RV);
        rd(4'd11, ST);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst    = ($urandom_range(0, 63) == 0);
            s.wr_en  = $urandom_range(0, 1) == 1;
            s.sel    = 4'($urandom_range(0, 15));
            s.mask   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       s.data = 32'hFFFF_FFFF;
                1:       s.data = 32'h0;
                default: s.data = $urandom;
            endcase
            s.pc_inc = $urandom_range(0, 1) == 1;
            s.alu_en = $urandom_range(0, 1) == 1;
            s.alu_in = 4'($urandom_range(0, 15));
            s.irq    = ($urandom_range(0, 3) == 0);
            s.ra     = 4'($urandom_range(0, 15));
            s.rb     = 4'($urandom_range(0, 15));
            apply(s);
        end

        apply(idle());
        repeat (3) @(negedge clk);
        #4;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
